// File: rtl/taxi_eth_tx_frame_arb.sv
// Frame-level round-robin arbiter that shares one MAC transmit stream among PORTS sources,
// tags frames with the source index and routes MAC completions back to the originating port.
module taxi_eth_tx_frame_arb #(
  parameter int PORTS           = 4,
  parameter int DATA_W          = 8,
  parameter int ID_W            = 8,
  parameter int CPL_W           = 96,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic [PORTS*DATA_W-1:0] s_axis_tdata,
  input  logic [PORTS-1:0]        s_axis_tvalid,
  output logic [PORTS-1:0]        s_axis_tready,
  input  logic [PORTS-1:0]        s_axis_tlast,
  input  logic [PORTS-1:0]        s_axis_tuser,

  output logic [DATA_W-1:0]       m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser,
  output logic [ID_W-1:0]         m_axis_tid,

  input  logic [CPL_W-1:0]        s_axis_cpl_tdata,
  input  logic [ID_W-1:0]         s_axis_cpl_tid,
  input  logic                    s_axis_cpl_tvalid,
  output logic                    s_axis_cpl_tready,

  output logic [CPL_W-1:0]        m_cpl_data,
  output logic [PORTS-1:0]        m_cpl_valid,
  output logic                    cpl_err,
  output logic                    busy
);

  localparam int PTR_W = $clog2(PORTS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {
    IDLE,
    XFER
  } state_t;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       grant_q, grant_d;
  logic [PTR_W-1:0]       rr_q, rr_d;
  logic [CNT_W-1:0]       cnt_q [PORTS];
  logic [CNT_W-1:0]       cnt_d [PORTS];
  logic [CPL_W-1:0]       cpl_data_q;
  logic [PORTS-1:0]       cpl_valid_q;
  logic                   cpl_err_q;
  logic                   cpl_rdy_q;

  logic [DATA_W-1:0]      s_data [PORTS];
  logic [PORTS-1:0]       elig;
  logic                   pick_found;
  logic [PTR_W-1:0]       pick_idx;
  logic [PTR_W:0]         scan;
  logic                   frame_done;
  logic                   cpl_fire;
  logic                   cpl_hit;
  logic [PTR_W-1:0]       cpl_port;
  logic [PORTS-1:0]       cpl_onehot;
  logic                   cpl_under;

  for (genvar gi = 0; gi < PORTS; gi++) begin : g_unpack
    assign s_data[gi] = s_axis_tdata[gi*DATA_W +: DATA_W];
  end

  // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    elig = '0;
    for (int i = 0; i < PORTS; i++) begin
      elig[i] = s_axis_tvalid[i] && (cnt_q[i] < CNT_W'(MAX_OUTSTANDING));
    end
  end

  // Rotating search starting just above the last port served.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan       = '0;
    for (int k = 1; k <= PORTS; k++) begin
      scan = {1'b0, rr_q} + (PTR_W+1)'(k);
      if (scan >= (PTR_W+1)'(PORTS)) scan = scan - (PTR_W+1)'(PORTS);
      if (!pick_found && elig[scan[PTR_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan[PTR_W-1:0];
      end
    end
  end

  assign frame_done = (state_q == XFER) && s_axis_tvalid[grant_q] &&
                      m_axis_tready && s_axis_tlast[grant_q];

  // FSM process 1: state register.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM process 2: next state, grant and round-robin pointer.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = XFER;
          grant_d = pick_idx;
        end
      end
      XFER: begin
        if (frame_done) begin
          state_d = IDLE;
          rr_d    = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM process 3: unbuffered pass-through from the granted port.
  always_comb begin
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    m_axis_tid    = '0;
    if (state_q == XFER) begin
      m_axis_tvalid          = s_axis_tvalid[grant_q];
      s_axis_tready[grant_q] = m_axis_tready;
      m_axis_tdata           = s_data[grant_q];
      m_axis_tlast           = s_axis_tlast[grant_q];
      m_axis_tuser           = s_axis_tuser[grant_q];
      m_axis_tid             = ID_W'(grant_q);
    end
  end

  assign cpl_fire = s_axis_cpl_tvalid && cpl_rdy_q;
  assign cpl_hit  = {1'b0, s_axis_cpl_tid} < (ID_W+1)'(PORTS);
  assign cpl_port = s_axis_cpl_tid[PTR_W-1:0];

  // Outstanding counters: +1 on a forwarded tlast, -1 on a matching completion, clamped at 0.
  always_comb begin
    cpl_onehot = '0;
    cpl_under  = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (frame_done && grant_q == PTR_W'(i)) cnt_d[i] = cnt_d[i] + CNT_W'(1);
      if (cpl_fire && cpl_hit && cpl_port == PTR_W'(i)) begin
        cpl_onehot[i] = 1'b1;
        if (cnt_q[i] == '0) cpl_under = 1'b1;
        else                cnt_d[i]  = cnt_d[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q     <= '0;
      rr_q        <= PTR_W'(PORTS - 1);
      // NOTE: the counter array is built from flops, so the async reset clears every entry.
      for (int i = 0; i < PORTS; i++) cnt_q[i] <= '0;
      cpl_data_q  <= '0;
      cpl_valid_q <= '0;
      cpl_err_q   <= 1'b0;
      cpl_rdy_q   <= 1'b0;
    end else begin
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      for (int i = 0; i < PORTS; i++) cnt_q[i] <= cnt_d[i];
      if (cpl_fire) cpl_data_q <= s_axis_cpl_tdata;
      cpl_valid_q <= cpl_onehot;
      cpl_err_q   <= cpl_fire && (!cpl_hit || cpl_under);
      cpl_rdy_q   <= 1'b1;
    end
  end

  assign s_axis_cpl_tready = cpl_rdy_q;
  assign m_cpl_data        = cpl_data_q;
  assign m_cpl_valid       = cpl_valid_q;
  assign cpl_err           = cpl_err_q;
  assign busy              = (state_q == XFER);

endmodule

// File: tb/tb_taxi_eth_tx_frame_arb.sv
// Self-checking bench for taxi_eth_tx_frame_arb: directed scenarios, a completion vector table
// and randomized traffic, all compared each cycle against a frame-level reference model.
module tb_taxi_eth_tx_frame_arb;

  localparam int PORTS = 4;
  localparam int DW    = 8;
  localparam int IDW   = 8;
  localparam int CW    = 96;
  localparam int MAXO  = 2;

  typedef struct packed {
    logic       last;
    logic       user;
    logic [7:0] data;
  } beat_t;

  typedef struct {
    logic [7:0]       tid;
    logic [CW-1:0]    data;
    logic [PORTS-1:0] exp_v;
    logic             exp_err;
  } cpl_vec_t;

  logic                  clk, rst_n;
  logic [PORTS*DW-1:0]   s_tdata;
  logic [PORTS-1:0]      s_tvalid, s_tready, s_tlast, s_tuser;
  logic [DW-1:0]         m_axis_tdata;
  logic                  m_axis_tvalid, m_tready, m_axis_tlast, m_axis_tuser;
  logic [IDW-1:0]        m_axis_tid;
  logic [CW-1:0]         cpl_data;
  logic [IDW-1:0]        cpl_tid;
  logic                  cpl_tvalid, cpl_tready;
  logic [CW-1:0]         m_cpl_data;
  logic [PORTS-1:0]      m_cpl_valid;
  logic                  cpl_err, busy;

  taxi_eth_tx_frame_arb #(
    .PORTS(PORTS), .DATA_W(DW), .ID_W(IDW), .CPL_W(CW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tid(m_axis_tid),
    .s_axis_cpl_tdata(cpl_data), .s_axis_cpl_tid(cpl_tid), .s_axis_cpl_tvalid(cpl_tvalid),
    .s_axis_cpl_tready(cpl_tready),
    .m_cpl_data(m_cpl_data), .m_cpl_valid(m_cpl_valid), .cpl_err(cpl_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Stimulus state
  beat_t        pq [PORTS][$];
  logic [7:0]   sent_log [PORTS][$];
  int           grant_log [$];
  int           gap_pct, mrdy_pct;
  bit           rand_cpl, rand_frames;
  logic         d_cpl_valid;
  logic [7:0]   d_cpl_tid;
  logic [CW-1:0] d_cpl_data;

  // Reference model: which port owns the MAC (-1 = arbitrating), last port served, in-flight counts
  int               m_gnt, m_rr;
  int               m_cnt [PORTS];
  logic [PORTS-1:0] e_cplv;
  logic             e_err, e_crdy;
  logic [CW-1:0]    e_cpld;

  logic             smp_tvalid, smp_busy;
  logic [7:0]       smp_tdata, smp_tid;
  logic [PORTS-1:0] smp_tready, smp_cplv;
  logic             smp_err;
  logic [CW-1:0]    smp_cpld;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_gnt  = -1;
    m_rr   = PORTS - 1;
    for (int i = 0; i < PORTS; i++) m_cnt[i] = 0;
    e_cplv = '0;
    e_err  = 1'b0;
    e_crdy = 1'b0;
    e_cpld = '0;
  endtask

  task automatic push_frame(input int p, input int len);
    for (int k = 0; k < len; k++) begin
      beat_t b;
      b.data = 8'($urandom);
      b.last = (k == len - 1);
      b.user = (k == len - 1) ? 1'($urandom_range(1)) : 1'b0;
      pq[p].push_back(b);
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < PORTS; i++) if (pq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive_inputs();
    if (rand_frames && $urandom_range(99) < 15) begin
      int p;
      p = int'($urandom_range(PORTS - 1));
      if (pq[p].size() < 12) push_frame(p, int'($urandom_range(1, 5)));
    end
    for (int i = 0; i < PORTS; i++) begin
      if (pq[i].size() > 0 && int'($urandom_range(99)) >= gap_pct) begin
        s_tvalid[i]        = 1'b1;
        s_tdata[i*DW +: DW] = pq[i][0].data;
        s_tlast[i]         = pq[i][0].last;
        s_tuser[i]         = pq[i][0].user;
      end else begin
        s_tvalid[i]        = 1'b0;
        s_tdata[i*DW +: DW] = 8'($urandom);
        s_tlast[i]         = 1'($urandom);
        s_tuser[i]         = 1'($urandom);
      end
    end
    m_tready = (int'($urandom_range(99)) < mrdy_pct);
    if (rand_cpl) begin
      cpl_tvalid = ($urandom_range(99) < 25);
      cpl_tid    = 8'($urandom_range(5));
      cpl_data   = {$urandom, $urandom, $urandom};
    end else begin
      cpl_tvalid = d_cpl_valid;
      cpl_tid    = d_cpl_tid;
      cpl_data   = d_cpl_data;
    end
  endtask

  task automatic model_compare();
    logic             ev, el, eu, eb;
    logic [PORTS-1:0] er;
    logic [7:0]       ed, eid;
    ev = 1'b0; el = 1'b0; eu = 1'b0; eb = 1'b0; er = '0; ed = '0; eid = '0;
    if (m_gnt >= 0) begin
      ev        = s_tvalid[m_gnt];
      er[m_gnt] = m_tready;
      ed        = s_tdata[m_gnt*DW +: DW];
      el        = s_tlast[m_gnt];
      eu        = s_tuser[m_gnt];
      eid       = 8'(m_gnt);
      eb        = 1'b1;
    end
    check("m_axis_tvalid", m_axis_tvalid, ev);
    check("s_axis_tready", s_tready, er);
    check("m_axis_tdata", m_axis_tdata, ed);
    check("m_axis_tlast", m_axis_tlast, el);
    check("m_axis_tuser", m_axis_tuser, eu);
    check("m_axis_tid", m_axis_tid, eid);
    check("busy", busy, eb);
    check("m_cpl_valid", m_cpl_valid, e_cplv);
    check("cpl_err", cpl_err, e_err);
    check("m_cpl_data", m_cpl_data, e_cpld);
    check("cpl_tready", cpl_tready, e_crdy);
    smp_tvalid = m_axis_tvalid; smp_tready = s_tready; smp_tdata = m_axis_tdata;
    smp_tid    = m_axis_tid;    smp_busy   = busy;     smp_cplv  = m_cpl_valid;
    smp_err    = cpl_err;       smp_cpld   = m_cpl_data;
  endtask

  task automatic model_seq();
    int inc, dec;
    inc = -1;
    dec = -1;
    if (m_gnt >= 0) begin
      if (s_tvalid[m_gnt] && m_tready) begin
        beat_t b;
        sent_log[m_gnt].push_back(smp_tdata);
        b = pq[m_gnt].pop_front();
        if (b.last) begin
          grant_log.push_back(int'(smp_tid));
          inc   = m_gnt;
          m_rr  = m_gnt;
          m_gnt = -1;
        end
      end
    end else begin
      for (int k = 1; k <= PORTS; k++) begin
        int p;
        p = (m_rr + k) % PORTS;
        if (m_gnt < 0 && s_tvalid[p] && m_cnt[p] < MAXO) m_gnt = p;
      end
    end
    e_cplv = '0;
    e_err  = 1'b0;
    if (cpl_tvalid && e_crdy) begin
      e_cpld = cpl_data;
      if (cpl_tid < PORTS) begin
        e_cplv[cpl_tid] = 1'b1;
        if (m_cnt[cpl_tid] == 0) e_err = 1'b1;
        else                     dec   = int'(cpl_tid);
      end else begin
        e_err = 1'b1;
      end
    end
    e_crdy = 1'b1;
    if (inc >= 0) m_cnt[inc]++;
    if (dec >= 0) m_cnt[dec]--;
  endtask

  // One clock: drive after the falling edge, compare, let the DUT clock, advance the model.
  task automatic cycle();
    drive_inputs();
    #1;
    model_compare();
    @(posedge clk);
    model_seq();
    @(negedge clk);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin
      cycle();
      n++;
    end
    check(name, pending(), 1'b0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_m_axis_tvalid", m_axis_tvalid, 1'b0);
    check("rst_s_axis_tready", s_tready, '0);
    check("rst_m_axis_tdata", m_axis_tdata, '0);
    check("rst_m_axis_tid", m_axis_tid, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_m_cpl_valid", m_cpl_valid, '0);
    check("rst_cpl_err", cpl_err, 1'b0);
    check("rst_cpl_tready", cpl_tready, 1'b0);
    check("rst_m_cpl_data", m_cpl_data, '0);
    for (int i = 0; i < PORTS; i++) begin
      pq[i].delete();
      sent_log[i].delete();
    end
    grant_log.delete();
    model_reset();
    rand_cpl = 1'b0; rand_frames = 1'b0; gap_pct = 0; mrdy_pct = 100;
    d_cpl_valid = 1'b0; d_cpl_tid = '0; d_cpl_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    cpl_vec_t   tbl [6];
    logic [7:0] first_byte;
    logic [7:0] exp_bytes [$];
    int         n, p0_early;
    bit         reloaded;

    // Completion vectors, applied with outstanding = {0,1,0,0} left behind by the first frame test.
    tbl[0] = '{8'd7, 96'h0000_1111_2222_3333_4444_5555, 4'b0000, 1'b1};
    tbl[1] = '{8'd2, 96'hA5A5_0000_FFFF_1234_5678_9ABC, 4'b0100, 1'b1};
    tbl[2] = '{8'd1, 96'hDEAD_BEEF_CAFE_F00D_0123_4567, 4'b0010, 1'b0};
    tbl[3] = '{8'd1, 96'h0F0F_0F0F_F0F0_F0F0_1357_9BDF, 4'b0010, 1'b1};
    tbl[4] = '{8'd4, 96'h8000_0000_0000_0000_0000_0001, 4'b0000, 1'b1};
    tbl[5] = '{8'd0, 96'h7654_3210_FEDC_BA98_0000_0042, 4'b0001, 1'b1};

    rst_n = 1'b0;
    s_tvalid = '0; s_tdata = '0; s_tlast = '0; s_tuser = '0; m_tready = 1'b0;
    cpl_tvalid = 1'b0; cpl_tid = '0; cpl_data = '0;
    @(negedge clk);
    do_reset();

    // Single 3-byte frame from port 1 with one arbitration cycle in front.
    push_frame(1, 3);
    first_byte = pq[1][0].data;
    cycle();
    check("t1_arb_cycle_tvalid", smp_tvalid, 1'b0);
    cycle();
    check("t1_first_tvalid", smp_tvalid, 1'b1);
    check("t1_first_tid", smp_tid, 8'd1);
    check("t1_first_tdata", smp_tdata, first_byte);
    cycle();
    cycle();
    cycle();
    check("t1_busy_after", smp_busy, 1'b0);
    check("t1_bytes_sent", sent_log[1].size(), 3);

    // Completion table: unknown tag, underflow, normal decrement.
    foreach (tbl[i]) begin
      d_cpl_valid = 1'b1;
      d_cpl_tid   = tbl[i].tid;
      d_cpl_data  = tbl[i].data;
      cycle();
      d_cpl_valid = 1'b0;
      cycle();
      check($sformatf("t4_vec%0d_valid", i), smp_cplv, tbl[i].exp_v);
      check($sformatf("t4_vec%0d_err", i), smp_err, tbl[i].exp_err);
      check($sformatf("t4_vec%0d_data", i), smp_cpld, tbl[i].data);
    end

    // Round robin: 0, 2, 3 together, then port 0 again.
    do_reset();
    push_frame(0, 2); push_frame(2, 2); push_frame(3, 2);
    reloaded = 1'b0;
    n = 0;
    while (pending() && n < 100) begin
      cycle();
      if (!reloaded && grant_log.size() >= 1) begin
        push_frame(0, 2);
        reloaded = 1'b1;
      end
      n++;
    end
    check("t2_timeout", pending(), 1'b0);
    check("t2_count", grant_log.size(), 4);
    check("t2_order0", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
    check("t2_order1", (grant_log.size() > 1) ? grant_log[1] : -1, 2);
    check("t2_order2", (grant_log.size() > 2) ? grant_log[2] : -1, 3);
    check("t2_order3", (grant_log.size() > 3) ? grant_log[3] : -1, 0);

    // Outstanding limit of 2 on port 0, released by one completion.
    do_reset();
    push_frame(0, 2); push_frame(0, 2); push_frame(0, 2);
    repeat (40) cycle();
    check("t3_limited_frames", grant_log.size(), 2);
    check("t3_held_bytes", pq[0].size(), 2);
    d_cpl_valid = 1'b1; d_cpl_tid = 8'd0; d_cpl_data = 96'h1;
    cycle();
    d_cpl_valid = 1'b0;
    cycle();
    check("t3_cpl_pulse", smp_cplv, 4'b0001);
    check("t3_cpl_err", smp_err, 1'b0);
    drain("t3_drain_timeout", 40);
    check("t3_third_frame", grant_log.size(), 3);

    // Port 3 frame with gaps and backpressure while port 0 waits.
    do_reset();
    gap_pct = 30; mrdy_pct = 50;
    push_frame(3, 8);
    foreach (pq[3][k]) exp_bytes.push_back(pq[3][k].data);
    n = 0;
    while (m_gnt != 3 && n < 50) begin cycle(); n++; end
    check("t5_grant_timeout", m_gnt, 3);
    push_frame(0, 3);
    n = 0;
    p0_early = 0;
    while (pq[3].size() > 0 && n < 400) begin
      cycle();
      if (smp_tready[0]) p0_early++;
      n++;
    end
    check("t5_p3_timeout", pq[3].size(), 0);
    check("t5_p0_blocked", p0_early, 0);
    check("t5_p3_len", sent_log[3].size(), exp_bytes.size());
    foreach (exp_bytes[k])
      check($sformatf("t5_p3_byte%0d", k), (k < sent_log[3].size()) ? sent_log[3][k] : 8'hxx,
            exp_bytes[k]);
    drain("t5_drain_timeout", 200);
    check("t5_p0_served", sent_log[0].size(), 3);

    // Randomized traffic, completions and backpressure against the model.
    do_reset();
    rand_cpl = 1'b1; rand_frames = 1'b1; gap_pct = 20; mrdy_pct = 70;
    repeat (3000) cycle();

    // Reset mid-frame, then port 0 must win first.
    do_reset();
    push_frame(3, 6);
    repeat (3) cycle();
    check("t6_mid_frame", smp_tvalid, 1'b1);
    do_reset();
    push_frame(3, 2); push_frame(0, 2);
    drain("t6_drain_timeout", 50);
    check("t6_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/taxi_eth_tx_frame_arb.md
Name: taxi_eth_tx_frame_arb

Overview:
- Frame-level round-robin arbiter that shares one 1G MAC transmit AXI stream (8-bit, tid-tagged) among PORTS requesters.
- Stamps each forwarded frame's tid with the source port index.
- Demultiplexes the MAC's transmit-completion stream back to the originating port.
- Limits each port's in-flight (sent, not yet completed) frames to MAX_OUTSTANDING.
- Sits between local frame sources and the MAC transmit/completion interfaces, in the MAC logic clock domain.

Parameters:
- PORTS, 4: number of requester ports, 2..16.
- DATA_W, 8: stream data width.
- ID_W, 8: tid width; must satisfy ID_W >= $clog2(PORTS).
- CPL_W, 96: completion payload width.
- MAX_OUTSTANDING, 4: maximum in-flight frames per port, 1..255.

Ports:
- clk  in  1  MAC logic clock.
- rst_n  in  1  asynchronous active-low reset.
- s_axis_tdata  in  PORTS*DATA_W  requester data, port i at slice i.
- s_axis_tvalid  in  PORTS  requester valid.
- s_axis_tready  out  PORTS  requester ready.
- s_axis_tlast  in  PORTS  requester end of frame.
- s_axis_tuser  in  PORTS  requester bad-frame flag.
- m_axis_tdata  out  DATA_W  data to MAC transmit.
- m_axis_tvalid  out  1  valid to MAC.
- m_axis_tready  in  1  ready from MAC.
- m_axis_tlast  out  1  end of frame to MAC.
- m_axis_tuser  out  1  bad-frame flag to MAC.
- m_axis_tid  out  ID_W  granted port index, zero-extended.
- s_axis_cpl_tdata  in  CPL_W  MAC completion payload.
- s_axis_cpl_tid  in  ID_W  completion tag.
- s_axis_cpl_tvalid  in  1  completion valid.
- s_axis_cpl_tready  out  1  completion ready, constant 1 out of reset.
- m_cpl_data  out  CPL_W  registered completion payload, shared by all ports.
- m_cpl_valid  out  PORTS  one-cycle completion pulse, one bit per port.
- cpl_err  out  1  one-cycle pulse on an unknown-tag or underflow completion.
- busy  out  1  high while in XFER.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; rr pointer = PORTS-1, so port 0 has first priority.
  - All outstanding counters = 0.
  - All outputs 0, except s_axis_cpl_tready, which is 0 during reset and 1 after release.
- Eligibility: port i is eligible when s_axis_tvalid[i]=1 and outstanding[i] < MAX_OUTSTANDING.
- IDLE:
  - Select the first eligible port searching from rr+1 upward, modulo PORTS.
  - Register it as grant and move to XFER on the next cycle.
  - Arbitration costs exactly 1 idle cycle per frame.
  - No eligible port: stay in IDLE.
  - All s_axis_tready = 0 and m_axis_tvalid = 0.
- XFER:
  - Combinational pass-through from port g: m_axis_tvalid = s_axis_tvalid[g] and s_axis_tready[g] = m_axis_tready.
  - tdata, tlast and tuser come from port g; m_axis_tid = g.
  - Other ports' tready = 0.
  - No added latency and no buffering.
  - The grant is held until a beat with tlast is accepted (tvalid & tready & tlast). No preemption; gaps in tvalid mid-frame keep the grant.
  - On the tlast handshake: rr = g, outstanding[g] increments, return to IDLE.
- Completion path:
  - Each cycle s_axis_cpl_tvalid=1 registers tdata into m_cpl_data.
  - If tid < PORTS, pulse m_cpl_valid[tid] on the next cycle and decrement outstanding[tid].
  - If tid >= PORTS: no port pulse, cpl_err pulses, counters unchanged.
  - Completion for a port whose count is already 0: m_cpl_valid still pulses, counter stays 0, cpl_err pulses.
- Simultaneous tlast handshake and completion for the same port in one cycle: net count unchanged.
- Counters are $clog2(MAX_OUTSTANDING+1) bits and never exceed MAX_OUTSTANDING, because grants are gated by eligibility.
- A port at the limit stays ineligible until its completion arrives. Other ports continue to be served.
- Reset mid-frame: everything returns to reset values immediately. The truncated frame is the MAC's responsibility.

Test Plan:
1. Port 1 only sends a 3-byte frame (tlast on byte 3), MAC always ready -> frame appears on m_axis with 1 idle cycle before the first beat, m_axis_tid=1, then busy=0, outstanding[1]=1.
2. Ports 0, 2 and 3 request simultaneously after reset -> frames are granted in order 0, 2, 3. Port 0 then re-requests while port 2 is also requesting -> order continues 2 then 0.
3. MAX_OUTSTANDING=2, port 0 sends 3 frames with no completions -> only 2 are forwarded. A completion with tid=0 -> m_cpl_valid[0] pulses one cycle later and the 3rd frame is forwarded.
4. Completion with tid=7 when PORTS=4 -> no m_cpl_valid bit set, cpl_err=1 for 1 cycle, counters unchanged. Completion with tid=2 when outstanding[2]=0 -> m_cpl_valid[2]=1, cpl_err=1.
5. Port 3 frame in progress with m_axis_tready toggling and s_axis_tvalid[3] gapping, port 0 requesting -> every port-3 byte is passed intact and in order. Port 0 gets no tready until port 3's tlast is accepted.
6. rst_n asserted mid-frame -> all outputs go to 0 asynchronously. After release, port 0 is granted first.
